// File: rtl/wb_commit_if.sv
// Writeback-stage bus into the register commit block: MEM/WB write payload,
// decode read ports and architectural state readback.
interface wb_commit_if #(
    parameter int unsigned N_REG      = 32,
    parameter int unsigned N_REG_ADDR = 5
);
    localparam int unsigned CNT_W = 32;

    logic [N_REG_ADDR-1:0] i_wb_waddr;
    logic [N_REG-1:0]      i_wb_wdata;
    logic                  i_wb_wen;
    logic                  i_wb_hilo_wen;
    logic [N_REG-1:0]      i_wb_hi;
    logic [N_REG-1:0]      i_wb_lo;
    logic                  i_wb_llbit_wen;
    logic                  i_wb_llbit_data;
    logic                  i_flush;
    logic                  i_re1;
    logic [N_REG_ADDR-1:0] i_raddr1;
    logic [N_REG-1:0]      o_rdata1;
    logic                  i_re2;
    logic [N_REG_ADDR-1:0] i_raddr2;
    logic [N_REG-1:0]      o_rdata2;
    logic [N_REG-1:0]      o_hi;
    logic [N_REG-1:0]      o_lo;
    logic                  o_llbit;
    logic [CNT_W-1:0]      o_commit_cnt;

    modport master (
        output i_wb_waddr, i_wb_wdata, i_wb_wen, i_wb_hilo_wen, i_wb_hi, i_wb_lo,
        output i_wb_llbit_wen, i_wb_llbit_data, i_flush,
        output i_re1, i_raddr1, i_re2, i_raddr2,
        input  o_rdata1, o_rdata2, o_hi, o_lo, o_llbit, o_commit_cnt
    );

    modport slave (
        input  i_wb_waddr, i_wb_wdata, i_wb_wen, i_wb_hilo_wen, i_wb_hi, i_wb_lo,
        input  i_wb_llbit_wen, i_wb_llbit_data, i_flush,
        input  i_re1, i_raddr1, i_re2, i_raddr2,
        output o_rdata1, o_rdata2, o_hi, o_lo, o_llbit, o_commit_cnt
    );
endinterface

// File: rtl/wb_commit.sv
// Writeback commit: GPR file with write-through read bypass, HI/LO pair,
// LLbit and a committed-GPR-write counter.
module wb_commit #(
    parameter int unsigned N_REG      = 32,
    parameter int unsigned N_REG_ADDR = 5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    wb_commit_if.slave  bus
);
    localparam int unsigned N_ENT = 1 << N_REG_ADDR;
    localparam int unsigned CNT_W = 32;

    logic [N_REG-1:0] gpr_q [N_ENT];
    logic [N_REG-1:0] hi_q, hi_d;
    logic [N_REG-1:0] lo_q, lo_d;
    logic             llbit_q, llbit_d;
    logic [CNT_W-1:0] commit_cnt_q, commit_cnt_d;
    logic             gpr_we_c;
    logic [N_REG-1:0] rdata1_c;
    logic [N_REG-1:0] rdata2_c;

    // Register 0 is hard-wired to zero, so a write to it is not a commit.
    assign gpr_we_c = bus.i_wb_wen && (bus.i_wb_waddr != N_REG_ADDR'(0));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(N_ENT); i++) begin
                gpr_q[i] <= '0;
            end
        end else if (gpr_we_c) begin
            gpr_q[bus.i_wb_waddr] <= bus.i_wb_wdata;
        end
    end

    always_comb begin
        hi_d         = hi_q;
        lo_d         = lo_q;
        llbit_d      = llbit_q;
        commit_cnt_d = commit_cnt_q;
        if (bus.i_wb_hilo_wen) begin
            hi_d = bus.i_wb_hi;
            lo_d = bus.i_wb_lo;
        end
        // Flush wins over an LL write retiring in the same cycle.
        if (bus.i_flush) begin
            llbit_d = 1'b0;
        end else if (bus.i_wb_llbit_wen) begin
            llbit_d = bus.i_wb_llbit_data;
        end
        if (gpr_we_c) begin
            commit_cnt_d = commit_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hi_q         <= '0;
            lo_q         <= '0;
            llbit_q      <= 1'b0;
            commit_cnt_q <= '0;
        end else begin
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            llbit_q      <= llbit_d;
            commit_cnt_q <= commit_cnt_d;
        end
    end

    // Read port 1: bypass the in-flight writeback so decode sees it this cycle.
    always_comb begin
        rdata1_c = '0;
        if (bus.i_re1 && (bus.i_raddr1 != N_REG_ADDR'(0))) begin
            if (bus.i_wb_wen && (bus.i_raddr1 == bus.i_wb_waddr)) begin
                rdata1_c = bus.i_wb_wdata;
            end else begin
                rdata1_c = gpr_q[bus.i_raddr1];
            end
        end
    end

    always_comb begin
        rdata2_c = '0;
        if (bus.i_re2 && (bus.i_raddr2 != N_REG_ADDR'(0))) begin
            if (bus.i_wb_wen && (bus.i_raddr2 == bus.i_wb_waddr)) begin
                rdata2_c = bus.i_wb_wdata;
            end else begin
                rdata2_c = gpr_q[bus.i_raddr2];
            end
        end
    end

    assign bus.o_rdata1     = rdata1_c;
    assign bus.o_rdata2     = rdata2_c;
    assign bus.o_hi         = hi_q;
    assign bus.o_lo         = lo_q;
    assign bus.o_llbit      = llbit_q;
    assign bus.o_commit_cnt = commit_cnt_q;
endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: directed writeback scenarios with a per-cycle
// comparison against an architectural model of the register state.
module tb_wb_commit;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;

    wb_commit_if #(.N_REG(32), .N_REG_ADDR(5)) bus ();

    wb_commit #(.N_REG(32), .N_REG_ADDR(5)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Architectural model: committed state, reset clears everything.
    logic [31:0] m_gpr [32];
    logic [31:0] m_hi, m_lo;
    logic        m_ll;
    logic [31:0] m_writes;
    logic [31:0] m_offset = 32'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_gpr[i] <= 32'h0;
            m_hi     <= 32'h0;
            m_lo     <= 32'h0;
            m_ll     <= 1'b0;
            m_writes <= 32'h0;
        end else begin
            if (bus.i_wb_wen && bus.i_wb_waddr != 5'd0) begin
                m_gpr[bus.i_wb_waddr] <= bus.i_wb_wdata;
                m_writes <= m_writes + 32'd1;
            end
            if (bus.i_wb_hilo_wen) begin
                m_hi <= bus.i_wb_hi;
                m_lo <= bus.i_wb_lo;
            end
            if (bus.i_flush) m_ll <= 1'b0;
            else if (bus.i_wb_llbit_wen) m_ll <= bus.i_wb_llbit_data;
        end
    end

    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
        if (!re || a == 5'd0) return 32'h0;
        if (bus.i_wb_wen && a == bus.i_wb_waddr) return bus.i_wb_wdata;
        return m_gpr[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("rdata1", bus.o_rdata1, exp_rd(bus.i_re1, bus.i_raddr1));
            check("rdata2", bus.o_rdata2, exp_rd(bus.i_re2, bus.i_raddr2));
            check("hi", bus.o_hi, m_hi);
            check("lo", bus.o_lo, m_lo);
            check("llbit", {31'h0, bus.o_llbit}, {31'h0, m_ll});
            check("commit_cnt", bus.o_commit_cnt, m_writes + m_offset);
        end
    end

    task automatic nop();
        bus.i_wb_wen        = 1'b0;
        bus.i_wb_hilo_wen   = 1'b0;
        bus.i_wb_llbit_wen  = 1'b0;
        bus.i_flush         = 1'b0;
        bus.i_re1           = 1'b0;
        bus.i_re2           = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.i_wb_wen   = 1'b1;
        bus.i_wb_waddr = a;
        bus.i_wb_wdata = d;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        bus.i_re1    = 1'b1;
        bus.i_raddr1 = a1;
        bus.i_re2    = 1'b1;
        bus.i_raddr2 = a2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.i_wb_waddr      = 5'd0;
        bus.i_wb_wdata      = 32'h0;
        bus.i_wb_hi         = 32'h0;
        bus.i_wb_lo         = 32'h0;
        bus.i_wb_llbit_data = 1'b0;
        bus.i_raddr1        = 5'd0;
        bus.i_raddr2        = 5'd0;
        nop();

        #1 rst_n = 1'b0;
        #2;
        check("reset_cnt", bus.o_commit_cnt, 32'h0);
        check("reset_hi", bus.o_hi, 32'h0);
        chk_en = 1'b1;
        #9 rst_n = 1'b1;

        // First write lands on the first edge after reset release.
        wr(5'd5, 32'hDEAD_BEEF);
        step();
        nop();
        rd(5'd5, 5'd6);
        #1;
        check("r5_read", bus.o_rdata1, 32'hDEAD_BEEF);
        check("cnt_after_r5", bus.o_commit_cnt, 32'd1);

        // Same-cycle write-through on both ports.
        nop();
        wr(5'd7, 32'h1234_5678);
        rd(5'd7, 5'd7);
        #1;
        check("bypass_p1", bus.o_rdata1, 32'h1234_5678);
        check("bypass_p2", bus.o_rdata2, 32'h1234_5678);
        step();

        // Writes to r0 are discarded and not counted.
        nop();
        wr(5'd0, 32'hFFFF_FFFF);
        rd(5'd0, 5'd0);
        step();
        nop();
        rd(5'd0, 5'd7);
        #1;
        check("r0_read", bus.o_rdata1, 32'h0);
        check("r7_read", bus.o_rdata2, 32'h1234_5678);
        check("cnt_r0", bus.o_commit_cnt, 32'd2);

        // HI/LO, then LLbit set, then flush overriding an LL write.
        nop();
        bus.i_wb_hilo_wen = 1'b1;
        bus.i_wb_hi = 32'hA;
        bus.i_wb_lo = 32'hB;
        step();
        check("hi_a", bus.o_hi, 32'hA);
        check("lo_b", bus.o_lo, 32'hB);
        nop();
        bus.i_wb_llbit_wen = 1'b1;
        bus.i_wb_llbit_data = 1'b1;
        step();
        check("ll_set", {31'h0, bus.o_llbit}, 32'h1);
        bus.i_flush = 1'b1;
        step();
        check("ll_flush", {31'h0, bus.o_llbit}, 32'h0);

        // All four updates in one cycle.
        nop();
        wr(5'd9, 32'hCAFE_0009);
        bus.i_wb_hilo_wen = 1'b1;
        bus.i_wb_hi = 32'h1111_2222;
        bus.i_wb_lo = 32'h3333_4444;
        bus.i_wb_llbit_wen = 1'b1;
        bus.i_wb_llbit_data = 1'b1;
        rd(5'd9, 5'd5);
        step();
        check("multi_hi", bus.o_hi, 32'h1111_2222);
        check("multi_cnt", bus.o_commit_cnt, 32'd3);

        // Bubble cycles with junk payloads and disabled read ports.
        nop();
        bus.i_wb_waddr = 5'd9;
        bus.i_wb_wdata = 32'hBAD0_BAD0;
        bus.i_wb_hi = 32'h5;
        bus.i_raddr1 = 5'd9;
        bus.i_raddr2 = 5'd5;
        step();
        step();
        rd(5'd9, 5'd31);
        #1;
        check("nop_r9", bus.o_rdata1, 32'hCAFE_0009);
        check("nop_ll", {31'h0, bus.o_llbit}, 32'h1);

        // Asynchronous reset mid-cycle, then a write presented during reset.
        nop();
        wr(5'd3, 32'h55);
        bus.i_wb_hilo_wen = 1'b1;
        bus.i_wb_hi = 32'h66;
        step();
        nop();
        rd(5'd3, 5'd4);
        #2;
        rst_n = 1'b0;
        m_offset = 32'h0;
        #1;
        check("rst_hi", bus.o_hi, 32'h0);
        check("rst_r3", bus.o_rdata1, 32'h0);
        check("rst_cnt", bus.o_commit_cnt, 32'h0);
        wr(5'd4, 32'h44);
        step();
        #3 rst_n = 1'b1;
        nop();
        rd(5'd4, 5'd3);
        #1;
        check("rst_drop_r4", bus.o_rdata1, 32'h0);
        step();

        // Counter wrap from a preloaded value.
        force dut.commit_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.commit_cnt_q;
        m_offset = 32'hFFFF_FFFE - m_writes;
        wr(5'd1, 32'h1);
        step();
        check("cnt_max", bus.o_commit_cnt, 32'hFFFF_FFFF);
        wr(5'd2, 32'h2);
        bus.i_flush = 1'b1;
        step();
        check("cnt_wrap", bus.o_commit_cnt, 32'h0);
        nop();
        step();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
